// File: rtl/binary_qkv_pkg.sv
// ----------------------------------------------------------------------------
// binary_qkv_pkg
// Shared constants, the Q/K/V matrix index enum and the default binary weight
// pattern for the streaming binary-weight Q/K/V projection (binary_qkv).
// Optional feature macro used by the top level: BINARY_QKV_WLOAD_EN.
// ----------------------------------------------------------------------------
package binary_qkv_pkg;

    localparam int DATA_W     = 16;
    localparam int VEC_LEN    = 30;
    localparam int OUT_DIM    = 8;
    localparam int NUM_BLOCKS = 4;
    localparam int ACC_W      = DATA_W + $clog2(VEC_LEN);
    localparam int NUM_MAT    = 3;

    typedef enum logic [1:0] {
        MAT_Q = 2'd0,
        MAT_K = 2'd1,
        MAT_V = 2'd2
    } mat_e;

    // Default weight bit for block b, matrix m, output row j, input element i.
    // 1 selects +x, 0 selects -x; the pattern is a checkerboard over b+m+j+i.
    function automatic logic default_w(input int b, input int m, input int j, input int i);
        return ((b + m + j + i) % 2) == 0;
    endfunction

endpackage

// File: rtl/binary_qkv_acc.sv
// ----------------------------------------------------------------------------
// binary_qkv_acc
// One signed +/-x accumulator. On an enabled cycle it either loads +/-x
// (i_load=1, first element of a vector) or adds +/-x to the running sum.
// The sign is chosen by the weight bit i_w (1 = +x, 0 = -x).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_en         element accepted this cycle
//   i_load       element is the first of a vector (restart the sum)
//   i_w          weight bit for this element
//   i_data       signed input element
//   o_sum_next   sum including this cycle's element (valid while i_en=1)
// ----------------------------------------------------------------------------
module binary_qkv_acc #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_load,
    input  logic                     i_w,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [ACC_W-1:0]  o_sum_next
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_base;

    // Sign-extend before negating so that -(-2^(DATA_W-1)) is representable.
    assign w_x        = {{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data};
    assign w_term     = i_w ? w_x : -w_x;
    assign w_base     = i_load ? '0 : r_acc;
    assign o_sum_next = w_base + w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum_next;
        end
    end

endmodule

// File: rtl/binary_qkv.sv
// ----------------------------------------------------------------------------
// binary_qkv
// Streaming binary-weight Q/K/V projection. One signed feature element is
// accepted per cycle with data_in_valid=1; VEC_LEN elements form a vector.
// Each element is multiplied by +/-1 weights of the block latched at the
// first element and accumulated into 3*OUT_DIM sums. When the last element
// is accepted the sums are copied into q_out/k_out/v_out and out_valid
// pulses for one cycle on the following clock edge.
//
// Handshake: data_in_valid is a pure valid with no ready; every cycle with
// data_in_valid=1 consumes one element. out_valid is a one-cycle pulse with
// no backpressure; outputs hold until the next vector completes.
//
// Optional feature: define BINARY_QKV_WLOAD_EN to add a weight-row write
// port (w_wr_en, w_wr_addr = {block[1:0], matrix[1:0], row[2:0]},
// w_wr_data = one VEC_LEN-bit row). Matrix index 3 is ignored. Reset always
// restores the default checkerboard weights.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   block_sel           weight set index, sampled on the first element
//   data_in             signed feature element
//   data_in_valid       data_in is valid this cycle
//   q_out/k_out/v_out   projection vectors, element j at [j*ACC_W +: ACC_W]
//   out_valid           one-cycle pulse when new results are presented
//   busy                a vector is partially received
// ----------------------------------------------------------------------------
module binary_qkv #(
    parameter int DATA_W     = binary_qkv_pkg::DATA_W,
    parameter int VEC_LEN    = binary_qkv_pkg::VEC_LEN,
    parameter int OUT_DIM    = binary_qkv_pkg::OUT_DIM,
    parameter int NUM_BLOCKS = binary_qkv_pkg::NUM_BLOCKS,
    parameter int ACC_W      = DATA_W + $clog2(VEC_LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               block_sel,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_in_valid,
`ifdef BINARY_QKV_WLOAD_EN
    input  logic                     w_wr_en,
    input  logic [6:0]               w_wr_addr,
    input  logic [VEC_LEN-1:0]       w_wr_data,
`endif
    output logic [OUT_DIM*ACC_W-1:0] q_out,
    output logic [OUT_DIM*ACC_W-1:0] k_out,
    output logic [OUT_DIM*ACC_W-1:0] v_out,
    output logic                     out_valid,
    output logic                     busy
);
    import binary_qkv_pkg::*;

    localparam int               IDX_W    = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    logic [IDX_W-1:0]        r_idx;
    logic [1:0]              r_blk;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out [NUM_MAT][OUT_DIM];
    logic signed [ACC_W-1:0] w_sum [NUM_MAT][OUT_DIM];

    logic       w_first;
    logic       w_last;
    logic [1:0] w_blk;

    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == LAST_IDX);
    // The first element must already use the incoming block_sel, since the
    // latch only takes it on the same edge.
    assign w_blk   = w_first ? block_sel : r_blk;

`ifdef BINARY_QKV_WLOAD_EN
    logic [VEC_LEN-1:0] r_w [NUM_BLOCKS][NUM_MAT][OUT_DIM];
    logic [1:0]         w_wr_blk;
    logic [1:0]         w_wr_mat;
    logic [2:0]         w_wr_row;

    assign w_wr_blk = w_wr_addr[6:5];
    assign w_wr_mat = w_wr_addr[4:3];
    assign w_wr_row = w_wr_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int m = 0; m < NUM_MAT; m++) begin
                    for (int j = 0; j < OUT_DIM; j++) begin
                        for (int i = 0; i < VEC_LEN; i++) begin
                            r_w[b][m][j][i] <= default_w(b, m, j, i);
                        end
                    end
                end
            end
        end else if (w_wr_en && (w_wr_mat != 2'd3)) begin
            r_w[w_wr_blk][w_wr_mat][w_wr_row] <= w_wr_data;
        end
    end
`endif

    for (genvar gm = 0; gm < NUM_MAT; gm++) begin : g_mat
        for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_row
            logic w_bit;
`ifdef BINARY_QKV_WLOAD_EN
            assign w_bit = r_w[w_blk][gm][gj][r_idx];
`else
            assign w_bit = default_w(int'(w_blk), gm, gj, int'(r_idx));
`endif
            binary_qkv_acc #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_acc (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_en       (data_in_valid),
                .i_load     (w_first),
                .i_w        (w_bit),
                .i_data     (data_in),
                .o_sum_next (w_sum[gm][gj])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_blk       <= '0;
            r_out_valid <= 1'b0;
            for (int m = 0; m < NUM_MAT; m++) begin
                for (int j = 0; j < OUT_DIM; j++) begin
                    r_out[m][j] <= '0;
                end
            end
        end else begin
            r_out_valid <= 1'b0;
            if (data_in_valid) begin
                if (w_first) begin
                    r_blk <= block_sel;
                end
                if (w_last) begin
                    r_idx       <= '0;
                    r_out_valid <= 1'b1;
                    for (int m = 0; m < NUM_MAT; m++) begin
                        for (int j = 0; j < OUT_DIM; j++) begin
                            r_out[m][j] <= w_sum[m][j];
                        end
                    end
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_pack
        assign q_out[gj*ACC_W +: ACC_W] = r_out[MAT_Q][gj];
        assign k_out[gj*ACC_W +: ACC_W] = r_out[MAT_K][gj];
        assign v_out[gj*ACC_W +: ACC_W] = r_out[MAT_V][gj];
    end

    assign out_valid = r_out_valid;
    // Any nonzero element index means a vector has been started but not ended.
    assign busy      = !w_first;

endmodule

// File: tb/tb_binary_qkv.sv
// ----------------------------------------------------------------------------
// tb_binary_qkv
// Self-checking bench for binary_qkv: randomized and directed vectors, a
// reference model computing each projection as a plain signed sum, an
// expected-result queue filled by the driver and drained by a monitor.
// Also exercises the weight write port when BINARY_QKV_WLOAD_EN is defined.
// ----------------------------------------------------------------------------
module tb_binary_qkv;
    import binary_qkv_pkg::*;

    localparam int VW = 3 * OUT_DIM * ACC_W;

    logic                     clk;
    logic                     rst_n;
    logic [1:0]               block_sel;
    logic signed [DATA_W-1:0] data_in;
    logic                     data_in_valid;
    logic [OUT_DIM*ACC_W-1:0] q_out;
    logic [OUT_DIM*ACC_W-1:0] k_out;
    logic [OUT_DIM*ACC_W-1:0] v_out;
    logic                     out_valid;
    logic                     busy;
`ifdef BINARY_QKV_WLOAD_EN
    logic                     w_wr_en;
    logic [6:0]               w_wr_addr;
    logic [VEC_LEN-1:0]       w_wr_data;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;

    logic [VW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [VW-1:0] last_out      = '0;
    logic          busy_at_pulse = 1'b0;
    logic          prev_ov       = 1'b0;

    int xs [VEC_LEN];
    bit tb_w [NUM_BLOCKS][3][OUT_DIM][VEC_LEN];

    binary_qkv u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .block_sel     (block_sel),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
`ifdef BINARY_QKV_WLOAD_EN
        .w_wr_en       (w_wr_en),
        .w_wr_addr     (w_wr_addr),
        .w_wr_data     (w_wr_data),
`endif
        .q_out         (q_out),
        .k_out         (k_out),
        .v_out         (v_out),
        .out_valid     (out_valid),
        .busy          (busy)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helpers ----------------
    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void init_weights();
        for (int b = 0; b < NUM_BLOCKS; b++)
            for (int m = 0; m < 3; m++)
                for (int j = 0; j < OUT_DIM; j++)
                    for (int i = 0; i < VEC_LEN; i++)
                        tb_w[b][m][j][i] = ((b + m + j + i) % 2) == 0;
    endfunction

    // Result laid out as {q_out, k_out, v_out}.
    function automatic logic [VW-1:0] model(input int bs);
        logic [VW-1:0]    r;
        logic [ACC_W-1:0] t;
        longint           s;
        r = '0;
        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < OUT_DIM; j++) begin
                s = 0;
                for (int i = 0; i < VEC_LEN; i++) s += tb_w[bs][m][j][i] ? xs[i] : -xs[i];
                t = ACC_W'(s);
                r[((2 - m) * OUT_DIM + j) * ACC_W +: ACC_W] = t;
            end
        end
        return r;
    endfunction

    function automatic int elem(input int m, input int j);
        logic signed [ACC_W-1:0] t;
        t = last_out[((2 - m) * OUT_DIM + j) * ACC_W +: ACC_W];
        return int'(t);
    endfunction

    // kind: 0 all ones, 1 +1/-1 alternating, 2 0x7FFF/0x8000 alternating, 3 random
    function automatic void fill_x(input int kind);
        for (int i = 0; i < VEC_LEN; i++) begin
            case (kind)
                0:       xs[i] = 1;
                1:       xs[i] = (i % 2 == 0) ? 1 : -1;
                2:       xs[i] = (i % 2 == 0) ? 32767 : -32768;
                default: xs[i] = int'($urandom_range(0, 65535)) - 32768;
            endcase
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int x, input logic [1:0] bs, input logic v);
        @(posedge clk);
        #1;
        data_in       = DATA_W'(x);
        block_sel     = bs;
        data_in_valid = v;
    endtask

    task automatic send_vector(input int kind, input int bs, input int gap_pct, input bit change_bs);
        logic [VW-1:0] e;
        logic [1:0]    b;
        fill_x(kind);
        e = model(bs);
        for (int i = 0; i < VEC_LEN; i++) begin
            if (i > 0 && int'($urandom_range(0, 99)) < gap_pct)
                repeat ($urandom_range(1, 2)) drive(int'($urandom_range(0, 65535)), block_sel, 1'b0);
            b = 2'(bs);
            if (change_bs && i > 0) b = 2'((bs + 1 + int'($urandom_range(0, 2))) % 4);
            drive(xs[i], b, 1'b1);
            if (i == 1 || i == VEC_LEN - 1) check_bit("busy_mid", busy, 1'b1);
        end
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic wait_result();
        drive(0, block_sel, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check_int("result_seen", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            exp_cyc_q.delete();
        end
        check_bit("busy_at_pulse", busy_at_pulse, 1'b0);
        check_bit("busy_idle", busy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n         = 1'b0;
        data_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_vec({tag, "_outs"}, {q_out, k_out, v_out}, '0);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_weights();
    endtask

`ifdef BINARY_QKV_WLOAD_EN
    task automatic write_row(input int b, input int m, input int j, input logic [VEC_LEN-1:0] d);
        @(posedge clk);
        #1;
        w_wr_en   = 1'b1;
        w_wr_addr = {2'(b), 2'(m), 3'(j)};
        w_wr_data = d;
        @(posedge clk);
        #1;
        w_wr_en = 1'b0;
        if (m != 3)
            for (int i = 0; i < VEC_LEN; i++) tb_w[b][m][j][i] = d[i];
    endtask
`endif

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    pulses++;
                    check_bit("pulse_width", prev_ov, 1'b0);
                    busy_at_pulse = busy;
                    last_out      = {q_out, k_out, v_out};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse act=pulse exp=none cyc=%0d", cyc);
                    end else begin
                        check_vec("qkv", last_out, exp_q.pop_front());
                        check_int("latency", cyc, exp_cyc_q.pop_front());
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        rst_n         = 1'b0;
        block_sel     = 2'd0;
        data_in       = '0;
        data_in_valid = 1'b0;
`ifdef BINARY_QKV_WLOAD_EN
        w_wr_en       = 1'b0;
        w_wr_addr     = '0;
        w_wr_data     = '0;
`endif
        init_weights();
        repeat (3) @(negedge clk);
        check_vec("reset_outs", {q_out, k_out, v_out}, '0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // all ones -> everything cancels to zero
        send_vector(0, 0, 0, 1'b0);
        wait_result();
        check_vec("ones_zero", last_out, '0);

        // alternating +1/-1, block 0
        send_vector(1, 0, 0, 1'b0);
        wait_result();
        check_int("alt_b0_q0", elem(0, 0), 30);
        check_int("alt_b0_q1", elem(0, 1), -30);
        check_int("alt_b0_k0", elem(1, 0), -30);
        check_int("alt_b0_v0", elem(2, 0), 30);

        // block 1, then block 1 with block_sel changing mid-vector
        send_vector(1, 1, 0, 1'b0);
        wait_result();
        check_int("alt_b1_q0", elem(0, 0), -30);
        check_int("alt_b1_k0", elem(1, 0), 30);
        send_vector(1, 1, 0, 1'b1);
        wait_result();
        check_int("alt_b1chg_q0", elem(0, 0), -30);
        check_int("alt_b1chg_k0", elem(1, 0), 30);

        // extreme magnitudes
        send_vector(2, 0, 0, 1'b0);
        wait_result();
        check_int("ext_q0", elem(0, 0), 983025);
        check_int("ext_q1", elem(0, 1), -983025);

        // back-to-back vectors, second with gaps
        p0 = pulses;
        send_vector(3, int'($urandom_range(0, 3)), 0, 1'b0);
        send_vector(3, int'($urandom_range(0, 3)), 30, 1'b0);
        wait_result();
        check_int("b2b_pulses", pulses, p0 + 2);

        // reset during element 12 of a third vector
        p0 = pulses;
        fill_x(3);
        for (int i = 0; i <= 12; i++) drive(xs[i], 2'd2, 1'b1);
        do_reset("midrst");
        repeat (3) @(negedge clk);
        check_int("midrst_no_pulse", pulses, p0);

        // random vectors with random blocks and gaps
        for (int n = 0; n < 6; n++) begin
            send_vector(3, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), n[0]);
            if (n % 2 == 1) wait_result();
        end

`ifdef BINARY_QKV_WLOAD_EN
        write_row(0, 3, 0, VEC_LEN'($urandom));
        write_row(0, 0, 0, '1);
        send_vector(0, 0, 0, 1'b0);
        wait_result();
        check_int("wload_q0", elem(0, 0), 30);
        check_int("wload_q1", elem(0, 1), 0);
        check_int("wload_k0", elem(1, 0), 0);
        do_reset("wrst");
        send_vector(0, 0, 0, 1'b0);
        wait_result();
        check_int("wrst_q0", elem(0, 0), 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
